// File: rtl/shift_seq_pkg.sv
// Shared encodings and sizing helpers for the multi-cycle shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_SRL  = 2'b00,
    OP_SRA  = 2'b01,
    OP_SLL  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Remaining-count width must hold the clamped amount L1 itself.
  function automatic int rem_width(input int l1);
    return $clog2(l1 + 1);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Narrow combinational shift stage: moves d_in by 0..STEP positions per call.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int L1   = 8,
  parameter int STEP = 4,
  parameter int KW   = $clog2(STEP + 1)
) (
  input  op_e             op,
  input  logic            fill,
  input  logic [L1-1:0]   d_in,
  input  logic [KW-1:0]   k,
  output logic [L1-1:0]   d_out
);

  logic [L1-1:0] fill_mask;

  always_comb begin
    // Ones in the k vacated MSB positions of a right shift.
    fill_mask = ~({L1{1'b1}} >> k);
    unique case (op)
      OP_SRL, OP_SRA: d_out = (d_in >> k) | (fill_mask & {L1{fill}});
      OP_SLL:         d_out = d_in << k;
      default:        d_out = d_in;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift sequencer controller: accepts one job, iterates the narrow stage, holds result.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int L1   = 8,
  parameter int L2   = 8,
  parameter int STEP = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [L1-1:0] in_data,
  input  logic [L2-1:0] in_amt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [L1-1:0] out_data,
  output logic          busy
);

  localparam int RW = rem_width(L1);
  localparam int KW = $clog2(STEP + 1);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [L1-1:0] data_q, data_d, step_out;
  logic [RW-1:0] rem_q, rem_d, amt_clamp;
  logic [KW-1:0] k;
  logic          fill;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;

  always_comb begin
    amt_clamp = (32'(in_amt) >= 32'(L1)) ? RW'(L1) : RW'(in_amt);
    k         = (rem_q > RW'(STEP)) ? KW'(STEP) : KW'(rem_q);
    // The working MSB stays the original sign across SRA steps.
    fill      = (op_q == OP_SRA) & data_q[L1-1];
  end

  shift_step #(.L1(L1), .STEP(STEP), .KW(KW)) u_step (
    .op    (op_q),
    .fill  (fill),
    .d_in  (data_q),
    .k     (k),
    .d_out (step_out)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        op_d    = op_e'(in_op);
        data_d  = in_data;
        rem_d   = amt_clamp;
        state_d = (op_e'(in_op) == OP_PASS || amt_clamp == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        data_d = step_out;
        rem_d  = rem_q - RW'(k);
        if (rem_d == '0) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_SRL;
      data_q      <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      rem_q       <= rem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a cycle-level reference model.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_op = 2'b00;
  logic [7:0] in_data = 8'h00;
  logic [7:0] in_amt = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       busy;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b1;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.L1(8), .L2(8), .STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  function automatic logic [7:0] model_res(input logic [1:0] op, input logic [7:0] d,
                                           input logic [7:0] amt);
    int a;
    int v;
    a = (int'(amt) > 8) ? 8 : int'(amt);
    case (op)
      2'b00: v = int'(d) >> a;
      2'b01: begin
        v = d[7] ? (int'(d) - 256) : int'(d);
        v = v >>> a;
      end
      2'b10: v = int'(d) << a;
      default: v = int'(d);
    endcase
    return v[7:0];
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [7:0] amt);
    int a;
    a = (int'(amt) > 8) ? 8 : int'(amt);
    if (op == 2'b11 || a == 0) return 1;
    return 1 + (a + 3) / 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: a job is pending for a fixed number of cycles, then holds until taken.
  bit         m_busy = 1'b0;
  int         m_left = 0;
  logic [7:0] m_res = 8'h00;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_left <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_res  <= model_res(in_op, in_data, in_amt);
        m_left <= model_lat(in_op, in_amt) - 1;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
    end else if (out_ready) begin
      m_busy <= 1'b0;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (cmp_en) begin
      chk("cyc in_ready", in_ready, !m_busy);
      chk("cyc busy", busy, m_busy);
      chk("cyc out_valid", out_valid, m_busy && m_left == 0);
      if (m_busy && m_left == 0) chk("cyc out_data", out_data, m_res);
    end
  end

  task automatic run_job(input string nm, input logic [1:0] op, input logic [7:0] d,
                         input logic [7:0] amt, input logic [7:0] exp_d, input int exp_lat,
                         input int hold);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({nm, " ready"}, in_ready, 1);
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = d;
    in_amt    = amt;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_op    = 2'($urandom);
    in_data  = 8'($urandom);
    in_amt   = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " data"}, out_data, exp_d);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk({nm, " hold valid"}, out_valid, 1);
      chk({nm, " hold data"}, out_data, exp_d);
      chk({nm, " hold in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " post valid"}, out_valid, 0);
    chk({nm, " post in_ready"}, in_ready, 1);
    chk({nm, " post busy"}, busy, 0);
  endtask

  initial begin
    chk("pin sra90", model_res(2'b01, 8'h90, 8'd3), 8'hF2);
    chk("pin sra80", model_res(2'b01, 8'h80, 8'd200), 8'hFF);
    chk("pin sll81", model_res(2'b10, 8'h81, 8'd9), 8'h00);
    chk("pin lat", model_lat(2'b00, 8'd7), 3);

    repeat (2) @(negedge clk);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 8'h00);
    chk("rst busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_job("sra90", 2'b01, 8'h90, 8'd3,   8'hF2, 2, 0);
    run_job("sra80", 2'b01, 8'h80, 8'd200, 8'hFF, 3, 0);
    run_job("srl80", 2'b00, 8'h80, 8'd7,   8'h01, 3, 0);
    run_job("sll81", 2'b10, 8'h81, 8'd9,   8'h00, 3, 0);
    run_job("sll01", 2'b10, 8'h01, 8'd0,   8'h01, 1, 0);
    run_job("pass",  2'b11, 8'h5A, 8'd6,   8'h5A, 1, 0);
    run_job("sra7f", 2'b01, 8'h7F, 8'd5,   8'h03, 3, 0);
    run_job("sll03", 2'b10, 8'h03, 8'd4,   8'h30, 2, 0);
    run_job("bp",    2'b00, 8'hF0, 8'd4,   8'h0F, 2, 5);

    // Reset while the SRA job is still shifting.
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_data  = 8'h80;
    in_amt   = 8'd8;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid rst busy", busy, 0);
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst in_ready", in_ready, 1);
    run_job("after rst", 2'b00, 8'h02, 8'd1, 8'h01, 2, 0);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
